// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational 32-bit ALU between
// two requesters. Operands/command are registered on accept, ALU outputs are
// captured one cycle later and returned tagged with the requester id.
// Optional build macro: ALU_STATS_EN adds saturating ops_done/ovf_count counters.
module alu_share_arbiter #(
  parameter int WIDTH = 32
`ifdef ALU_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [2:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow
`ifdef ALU_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] ops_done,
  output logic [CNT_WIDTH-1:0] ovf_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rr_ptr;
  logic               w_any_vld;
  logic               w_grant_id;
  logic               w_accept;
  logic               w_rsp_hs;
  logic [1:0]         w_req_ready;
  logic [2:0]         w_cmd_sel;
  logic [WIDTH-1:0]   w_a_sel;
  logic [WIDTH-1:0]   w_b_sel;

  logic [2:0]         r_alu_cmd_p0;
  logic [WIDTH-1:0]   r_alu_a_p0;
  logic [WIDTH-1:0]   r_alu_b_p0;
  logic               r_id_p0;

  logic               r_rsp_id_p1;
  logic [WIDTH-1:0]   r_rsp_result_p1;
  logic               r_rsp_carry_p1;
  logic               r_rsp_ovf_p1;
  logic               r_rsp_zero_p1;
  logic               w_vld_p1;

  // With both requesting, rr_ptr decides; a lone requester wins regardless.
  assign w_any_vld  = |req_valid;
  assign w_grant_id = (&req_valid) ? r_rr_ptr : req_valid[1];
  assign w_cmd_sel  = w_grant_id ? req1_cmd : req0_cmd;
  assign w_a_sel    = w_grant_id ? req1_a   : req0_a;
  assign w_b_sel    = w_grant_id ? req1_b   : req0_b;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, grant and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_vld) begin
          w_req_ready = w_grant_id ? 2'b10 : 2'b01;
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        // Returning to IDLE costs a cycle: no accept in the handshake cycle.
        if (rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: register the granted command/operands and advance round-robin
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_cmd_p0 <= '0;
      r_alu_a_p0   <= '0;
      r_alu_b_p0   <= '0;
      r_id_p0      <= 1'b0;
      r_rr_ptr     <= 1'b0;
    end else if (w_accept) begin
      r_alu_cmd_p0 <= w_cmd_sel;
      r_alu_a_p0   <= w_a_sel;
      r_alu_b_p0   <= w_b_sel;
      r_id_p0      <= w_grant_id;
      r_rr_ptr     <= ~w_grant_id;
    end
  end

  // Stage p1: capture settled ALU outputs; zero flag derived locally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_id_p1     <= 1'b0;
      r_rsp_result_p1 <= '0;
      r_rsp_carry_p1  <= 1'b0;
      r_rsp_ovf_p1    <= 1'b0;
      r_rsp_zero_p1   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_id_p1     <= r_id_p0;
      r_rsp_result_p1 <= alu_result;
      r_rsp_carry_p1  <= alu_carryout;
      r_rsp_ovf_p1    <= alu_overflow;
      r_rsp_zero_p1   <= ~|alu_result;
    end
  end

  assign w_vld_p1     = (r_state == S_RESP);

  assign req_ready    = w_req_ready;
  assign alu_cmd      = r_alu_cmd_p0;
  assign alu_a        = r_alu_a_p0;
  assign alu_b        = r_alu_b_p0;
  assign rsp_valid    = w_vld_p1;
  assign rsp_id       = r_rsp_id_p1;
  assign rsp_result   = r_rsp_result_p1;
  assign rsp_carryout = r_rsp_carry_p1;
  assign rsp_overflow = r_rsp_ovf_p1;
  assign rsp_zero     = r_rsp_zero_p1;

`ifdef ALU_STATS_EN
  logic [CNT_WIDTH-1:0] r_ops_done;
  logic [CNT_WIDTH-1:0] r_ovf_count;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Count completed responses and the overflowing ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ops_done  <= '0;
      r_ovf_count <= '0;
    end else if (w_rsp_hs) begin
      r_ops_done <= sat_inc(r_ops_done);
      if (r_rsp_ovf_p1) r_ovf_count <= sat_inc(r_ovf_count);
    end
  end

  assign ops_done  = r_ops_done;
  assign ovf_count = r_ovf_count;
`endif

endmodule
